// File: rtl/hilo_unit_ctrl_if.sv
// Bundle between the EX/ID pipeline stages and the HI/LO sequencing controller.
// The master side is the pipeline, the slave side is the controller.
interface hilo_unit_ctrl_if #(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 32
);
    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    logic             ex_valid;
    logic [5:0]       ex_opcode;
    logic [5:0]       ex_funct;
    logic [5:0]       id_opcode;
    logic [5:0]       id_funct;
    logic             i_abort;
    logic             o_mul_start;
    logic             o_div_start;
    logic             o_signed;
    logic             o_res_is_div;
    logic             o_hilo_we;
    logic             o_hi_we;
    logic             o_lo_we;
    logic             o_busy;
    logic             o_stall;
    logic [CNT_W-1:0] o_cnt;

    modport master (
        output ex_valid, ex_opcode, ex_funct, id_opcode, id_funct, i_abort,
        input  o_mul_start, o_div_start, o_signed, o_res_is_div, o_hilo_we,
        input  o_hi_we, o_lo_we, o_busy, o_stall, o_cnt
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_funct, id_opcode, id_funct, i_abort,
        output o_mul_start, o_div_start, o_signed, o_res_is_div, o_hilo_we,
        output o_hi_we, o_lo_we, o_busy, o_stall, o_cnt
    );
endinterface

// File: rtl/hilo_unit_ctrl.sv
// Sequencing controller for the multi-cycle multiply/divide units and HI/LO.
// Starts the selected unit, counts its fixed latency, pulses the HI/LO write
// and stalls any HI/LO consumer or producer in ID while an operation is live.
module hilo_unit_ctrl #(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 32
) (
    input logic               i_clk,
    input logic               i_rst,
    hilo_unit_ctrl_if.slave   bus
);
    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_is_div_q, res_is_div_d;

    logic ex_is_r, ex_op, ex_is_div, id_hilo, accept, busy, cnt_zero;

    // Instruction decode and the accept condition.
    always_comb begin
        ex_is_r   = (bus.ex_opcode == 6'd0);
        // MULT/MULTU/DIV/DIVU occupy funct 0x18..0x1B.
        ex_op     = bus.ex_valid && ex_is_r && (bus.ex_funct[5:2] == 4'b0110);
        ex_is_div = bus.ex_funct[1];
        // HI/LO moves 0x10..0x13 or mul/div 0x18..0x1B.
        id_hilo   = (bus.id_opcode == 6'd0) &&
                    ((bus.id_funct[5:2] == 4'b0100) || (bus.id_funct[5:2] == 4'b0110));
        busy      = (state_q == ST_BUSY);
        cnt_zero  = (cnt_q == '0);
        accept    = ex_op && !busy && !bus.i_abort;
    end

    // Combinational outputs.
    always_comb begin
        bus.o_mul_start  = accept && !ex_is_div;
        bus.o_div_start  = accept && ex_is_div;
        bus.o_signed     = accept && !bus.ex_funct[0];
        // Abort in the final cycle discards the result.
        bus.o_hilo_we    = busy && cnt_zero && !bus.i_abort;
        bus.o_hi_we      = bus.ex_valid && !busy && ex_is_r && (bus.ex_funct == 6'h11);
        bus.o_lo_we      = bus.ex_valid && !busy && ex_is_r && (bus.ex_funct == 6'h13);
        bus.o_busy       = busy;
        bus.o_stall      = id_hilo && (busy || accept);
        bus.o_res_is_div = res_is_div_q;
        bus.o_cnt        = cnt_q;
    end

    // Next-state: load latency on accept, count down while busy, leave on zero or abort.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        res_is_div_d = res_is_div_q;
        if (busy) begin
            if (bus.i_abort) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (cnt_zero) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (accept) begin
            state_d      = ST_BUSY;
            cnt_d        = ex_is_div ? DIV_LOAD : MUL_LOAD;
            res_is_div_d = ex_is_div;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            res_is_div_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            res_is_div_q <= res_is_div_d;
        end
    end
endmodule
